// File: rtl/mult_fu.sv
// Pipelined 64x64 integer multiply unit. Results wait at the CDB until they are granted.
// In-flight entries carry branch masks so they can be cleared or squashed on branch resolution.
module mult_fu #(
    parameter int STAGES   = 4,
    parameter int PREG_W   = 6,
    parameter int BS_PTR_W = 2,
    parameter int BMASK_W  = 4,
    parameter int ZERO_REG = 63
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fus_en,
    input  logic [63:0]         fus_opA,
    input  logic [63:0]         fus_opB,
    input  logic [PREG_W-1:0]   fus_tagDest,
    input  logic [1:0]          fus_func,
    input  logic [BMASK_W-1:0]  fus_bmask,
    input  logic                br_en,
    input  logic [BS_PTR_W-1:0] br_ptr,
    input  logic                br_mispredict,
    input  logic                cdb_grant,
    output logic                fu_ready,
    output logic                cdb_req,
    output logic [63:0]         cdb_result,
    output logic [PREG_W-1:0]   cdb_tag,
    output logic [BMASK_W-1:0]  cdb_bmask
);
    // Datapath split: stage 0 operands, 1 partial products, 2 full product, 3.. result.
    localparam int LAST = STAGES - 1;

    function automatic logic [127:0] sum_partials(input logic [63:0] ll, input logic [63:0] lh,
                                                  input logic [63:0] hl, input logic [63:0] hh);
        return {hh, ll} + {32'd0, lh, 32'd0} + {32'd0, hl, 32'd0};
    endfunction

    function automatic logic [63:0] select_result(input logic [1:0] func, input logic [127:0] prod);
        logic [63:0] res;
        case (func)
            2'd0:    res = prod[63:0];
            2'd1:    res = prod[127:64];
            2'd2:    res = {{32{prod[31]}}, prod[31:0]};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    logic [STAGES-1:0]  valid_q, valid_d;
    logic [PREG_W-1:0]  tag_q   [STAGES];
    logic [PREG_W-1:0]  tag_d   [STAGES];
    logic [BMASK_W-1:0] bmask_q [STAGES];
    logic [BMASK_W-1:0] bmask_d [STAGES];
    logic [1:0]         func_q  [3];
    logic [1:0]         func_d  [3];
    logic [63:0]        opa_q, opa_d, opb_q, opb_d;
    logic [63:0]        pp_q    [4];
    logic [63:0]        pp_d    [4];
    logic [127:0]       prod_q, prod_d;
    logic [63:0]        res_q   [3:STAGES-1];
    logic [63:0]        res_d   [3:STAGES-1];

    logic [BMASK_W-1:0] br_onehot_s;
    logic [BMASK_W-1:0] keep_mask_s;
    logic               kill_s;
    logic [STAGES-1:0]  live_s;
    logic [STAGES-1:0]  free_s;
    logic               issue_ok_s;

    // Branch decode, squash detection and the back-to-front advance chain.
    always_comb begin
        br_onehot_s = BMASK_W'(1'b1) << br_ptr;
        kill_s      = br_en & br_mispredict;
        if (br_en & ~br_mispredict) begin
            keep_mask_s = ~br_onehot_s;
        end else begin
            keep_mask_s = {BMASK_W{1'b1}};
        end
        live_s = {STAGES{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            live_s[i] = valid_q[i] & ~(kill_s & (|(bmask_q[i] & br_onehot_s)));
        end
        // A squashed slot counts as empty, so a squash can let the entries behind it move up.
        free_s       = {STAGES{1'b0}};
        free_s[LAST] = ~live_s[LAST] | cdb_grant;
        for (int i = LAST - 1; i >= 0; i--) begin
            free_s[i] = ~live_s[i] | free_s[i+1];
        end
        issue_ok_s = fus_en & free_s[0] & ~(kill_s & (|(fus_bmask & br_onehot_s)));
    end

    // Per-stage control: load from upstream when free, otherwise hold; masks always see the clear.
    always_comb begin
        valid_d    = {STAGES{1'b0}};
        valid_d[0] = free_s[0] ? issue_ok_s : live_s[0];
        tag_d[0]   = free_s[0] ? fus_tagDest : tag_q[0];
        bmask_d[0] = (free_s[0] ? fus_bmask : bmask_q[0]) & keep_mask_s;
        func_d[0]  = free_s[0] ? fus_func : func_q[0];
        for (int i = 1; i < STAGES; i++) begin
            if (free_s[i]) begin
                valid_d[i] = live_s[i-1];
                tag_d[i]   = tag_q[i-1];
                bmask_d[i] = bmask_q[i-1] & keep_mask_s;
            end else begin
                valid_d[i] = live_s[i];
                tag_d[i]   = tag_q[i];
                bmask_d[i] = bmask_q[i] & keep_mask_s;
            end
        end
        for (int i = 1; i < 3; i++) begin
            func_d[i] = free_s[i] ? func_q[i-1] : func_q[i];
        end
    end

    // Arithmetic datapath, advancing in lockstep with the control.
    always_comb begin
        opa_d = free_s[0] ? fus_opA : opa_q;
        opb_d = free_s[0] ? fus_opB : opb_q;
        if (free_s[1]) begin
            pp_d[0] = {32'd0, opa_q[31:0]}  * {32'd0, opb_q[31:0]};
            pp_d[1] = {32'd0, opa_q[31:0]}  * {32'd0, opb_q[63:32]};
            pp_d[2] = {32'd0, opa_q[63:32]} * {32'd0, opb_q[31:0]};
            pp_d[3] = {32'd0, opa_q[63:32]} * {32'd0, opb_q[63:32]};
        end else begin
            for (int i = 0; i < 4; i++) begin
                pp_d[i] = pp_q[i];
            end
        end
        prod_d   = free_s[2] ? sum_partials(pp_q[0], pp_q[1], pp_q[2], pp_q[3]) : prod_q;
        res_d[3] = free_s[3] ? select_result(func_q[2], prod_q) : res_q[3];
        for (int i = 4; i < STAGES; i++) begin
            res_d[i] = free_s[i] ? res_q[i-1] : res_q[i];
        end
    end

    // Pipeline registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= {STAGES{1'b0}};
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i]   <= PREG_W'(ZERO_REG);
                bmask_q[i] <= {BMASK_W{1'b0}};
            end
            for (int i = 0; i < 3; i++) begin
                func_q[i] <= 2'd0;
            end
            opa_q  <= 64'd0;
            opb_q  <= 64'd0;
            for (int i = 0; i < 4; i++) begin
                pp_q[i] <= 64'd0;
            end
            prod_q <= 128'd0;
            for (int i = 3; i < STAGES; i++) begin
                res_q[i] <= 64'd0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i]   <= tag_d[i];
                bmask_q[i] <= bmask_d[i];
            end
            for (int i = 0; i < 3; i++) begin
                func_q[i] <= func_d[i];
            end
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            for (int i = 0; i < 4; i++) begin
                pp_q[i] <= pp_d[i];
            end
            prod_q <= prod_d;
            for (int i = 3; i < STAGES; i++) begin
                res_q[i] <= res_d[i];
            end
        end
    end

    // CDB drive from the final stage; the request drops at once if that entry is being squashed.
    always_comb begin
        fu_ready = free_s[0];
        cdb_req  = live_s[LAST];
        if (valid_q[LAST]) begin
            cdb_result = res_q[LAST];
            cdb_tag    = tag_q[LAST];
            cdb_bmask  = bmask_q[LAST];
        end else begin
            cdb_result = 64'd0;
            cdb_tag    = PREG_W'(ZERO_REG);
            cdb_bmask  = {BMASK_W{1'b0}};
        end
    end

    mult_fu_checker u_checker (
        .clock    (clock),
        .reset    (reset),
        .fus_en   (fus_en),
        .fu_ready (fu_ready)
    );
endmodule

// Protocol checker: upstream must not issue while the unit is full.
module mult_fu_checker (
    input logic clock,
    input logic reset,
    input logic fus_en,
    input logic fu_ready
);
    issue_while_busy: assert property (@(posedge clock) disable iff (!reset) !(fus_en && !fu_ready));
endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined 64-bit integer multiply functional unit sitting directly downstream of the FU-select stage.
- Accepts at most one issued instruction per cycle (operands, destination tag, branch mask) and produces a result after STAGES cycles.
- Requests the CDB and holds its result until granted.
- Tracks branch masks in flight: clears resolved bits on correct prediction and squashes dependent instructions on misprediction.

Parameters:
- STAGES, 4: pipeline depth; minimum issue-to-cdb_req latency in cycles.
- PREG_W, 6: physical register tag width.
- BS_PTR_W, 2: branch-stack pointer width.
- BMASK_W, 4: branch mask width (one bit per branch-stack entry, equal to 2**BS_PTR_W).
- ZERO_REG, 63: physical zero-register tag, driven on cdb_tag when idle.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- fus_en  in  1  valid issue this cycle
- fus_opA  in  64  operand A
- fus_opB  in  64  operand B
- fus_tagDest  in  PREG_W  destination physical tag
- fus_func  in  2  0=MULQ (low 64 bits), 1=UMULH (high 64 bits, unsigned), 2=MULL (low 32 bits sign-extended to 64), 3=reserved (result 0)
- fus_bmask  in  BMASK_W  branch dependency mask of the issued instruction
- br_en  in  1  branch resolution this cycle
- br_ptr  in  BS_PTR_W  branch-stack index being resolved
- br_mispredict  in  1  resolution outcome: 1=mispredicted, 0=correct
- cdb_grant  in  1  CDB grant for this FU
- fu_ready  out  1  FU can accept an issue this cycle
- cdb_req  out  1  result valid, requesting the CDB
- cdb_result  out  64  result value
- cdb_tag  out  PREG_W  destination tag of the result
- cdb_bmask  out  BMASK_W  current branch mask of the result

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valid bits clear.
  - cdb_req=0, cdb_result=0, cdb_tag=ZERO_REG, cdb_bmask=0, fu_ready=1.
  - Reset mid-operation discards every in-flight instruction.
- Pipeline structure:
  - STAGES registered stages, each holding valid, tag, bmask, func and partial-product state.
  - The final stage drives the cdb_* outputs.
- Advance rule:
  - The final stage empties when cdb_grant=1 and cdb_req=1.
  - Stage i advances when stage i+1 is empty or advancing.
  - Bubbles therefore compress: a stalled tail does not block entries behind an empty slot.
- Issue:
  - fu_ready = stage 0 empty or advancing (combinational).
  - fus_en=1 while fu_ready=0 is an upstream protocol error; the input is dropped and an assertion fires in simulation.
- Latency:
  - Issue in cycle t with no stall gives cdb_req=1 in cycle t+STAGES.
  - Throughput is 1 per cycle while granted every cycle.
- Arithmetic:
  - Full 128-bit unsigned product of opA and opB.
  - MULQ returns bits [63:0].
  - UMULH returns bits [127:64].
  - MULL returns sign-extended bits [31:0].
  - Partitioning across stages is implementation-free; only the final result is checked.
- cdb outputs when the final stage is invalid: cdb_result=0, cdb_tag=ZERO_REG, cdb_bmask=0.
- Branch resolution (br_en=1), bit b = br_ptr:
  - Correct (br_mispredict=0): clear bit b in every valid stage's bmask, and in fus_bmask if an issue is accepted the same cycle.
  - Mispredict (br_mispredict=1): invalidate every stage whose bmask bit b=1, and drop a same-cycle issue whose fus_bmask bit b=1.
  - cdb_req is masked combinationally when the final entry is squashed in that cycle. A same-cycle grant is then ignored.
  - Squashed slots count as empty for that cycle's advance rule.
- Resolution updates apply to the value being written into the next stage, so a moving entry is never missed.
- Stalled final stage: cdb_result, cdb_tag and cdb_bmask stay stable while cdb_req=1 and cdb_grant=0. The only exception is cdb_bmask bit clearing on a correct resolution.

Test Plan:
- Reset, then issue MULQ opA=3, opB=5, tag=7, cdb_grant tied 1 -> cdb_req=1 exactly 4 cycles later, cdb_result=15, cdb_tag=7; idle outputs 0/63 before and after.
- UMULH opA=opB=0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFFFFFFFFFE. MULL opA=0x80000000, opB=1 -> result 0xFFFFFFFF80000000.
- Issue 4 back-to-back instructions with cdb_grant=0 -> pipeline fills, fu_ready=0 after the 4th, cdb_req and outputs held. Raise grant -> results retire in issue order, one per cycle, fu_ready returns to 1.
- Two in-flight instructions with bmask 0010 and 0001, then br_en=1, br_ptr=1, br_mispredict=1 -> first squashed (never requests the CDB), second completes normally.
- Final stage stalled with bmask 0100, then br_en=1, br_ptr=2, br_mispredict=0 -> cdb_bmask becomes 0000 next cycle, result unchanged.
- Squash of the final entry in the same cycle as cdb_grant=1 -> cdb_req=0 that cycle, no result delivered. Then assert reset mid-fill -> all valids clear asynchronously, cdb_req=0 immediately.
